// File: rtl/pulse_to_level_pkg.sv
// Shared types and constants for the pulse-to-level stretcher.
package pulse_to_level_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RETRIG  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE  = 2'd2;

  // Guard counter width; a zero-length guard still gets a 1-bit counter.
  function automatic int unsigned guard_w(input int unsigned ticks);
    if (ticks == 0) return 1;
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a decrement enable; never wraps below zero.
module hold_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         is_one_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/pulse_to_level.sv
// Turns single-cycle trigger pulses into a held level: one-shot, retriggerable
// stretch or toggle, with an optional lockout window after the level falls.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int unsigned HOLD_W      = 8,
  parameter int unsigned GUARD_TICKS = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              pulse_i,
  input  logic                              tick_i,
  input  logic [1:0]                        mode_i,
  input  logic [HOLD_W-1:0]                 hold_cycles_i,
  input  logic                              clear_i,
  output logic                              level_o,
  output logic                              busy_o,
  output logic [HOLD_W-1:0]                 remaining_o,
  output logic                              dropped_o,
  output state_e                            state_o,
  output logic [guard_w(GUARD_TICKS)-1:0]   guard_cnt_o
);

  localparam int unsigned    GW         = guard_w(GUARD_TICKS);
  localparam logic [GW-1:0]  GUARD_LOAD = GW'(GUARD_TICKS);
  localparam logic           HAS_GUARD  = (GUARD_TICKS > 0);
  localparam state_e         EXIT_ST    = HAS_GUARD ? ST_GUARD : ST_IDLE;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        dropped_q, dropped_d;
  logic [1:0]  eff_mode;

  logic              hold_load, hold_dec, hold_clr, hold_is_one;
  logic [HOLD_W-1:0] hold_cnt;
  logic              guard_load, guard_dec, guard_clr, guard_is_one;
  logic [GW-1:0]     guard_cnt;

  hold_counter #(.W(HOLD_W)) u_hold (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (hold_clr),
    .load_i     (hold_load),
    .load_val_i (hold_cycles_i),
    .dec_i      (hold_dec),
    .count_o    (hold_cnt),
    .is_one_o   (hold_is_one)
  );

  hold_counter #(.W(GW)) u_guard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (guard_clr),
    .load_i     (guard_load),
    .load_val_i (GUARD_LOAD),
    .dec_i      (guard_dec),
    .count_o    (guard_cnt),
    .is_one_o   (guard_is_one)
  );

  assign eff_mode = (mode_i == 2'd3) ? MODE_ONESHOT : mode_i;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dropped_d  = 1'b0;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    hold_clr   = 1'b0;
    guard_load = 1'b0;
    guard_dec  = 1'b0;
    guard_clr  = 1'b0;
    // Clear wins over everything and swallows a coincident pulse silently.
    if (clear_i) begin
      state_d   = ST_IDLE;
      hold_clr  = 1'b1;
      guard_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_i) begin
            if (eff_mode == MODE_TOGGLE) begin
              state_d = ST_ACTIVE;
              mode_d  = MODE_TOGGLE;
            end else if (hold_cycles_i == '0) begin
              dropped_d = 1'b1;
            end else begin
              state_d   = ST_ACTIVE;
              mode_d    = eff_mode;
              hold_load = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (mode_q == MODE_TOGGLE) begin
            if (pulse_i) begin
              state_d    = EXIT_ST;
              guard_load = HAS_GUARD;
            end
          end else if (pulse_i && (mode_q == MODE_RETRIG) && (hold_cycles_i != '0)) begin
            // Reload takes precedence over an expiring tick: no gap in level.
            hold_load = 1'b1;
          end else begin
            dropped_d = pulse_i;
            hold_dec  = tick_i;
            if (tick_i && hold_is_one) begin
              state_d    = EXIT_ST;
              guard_load = HAS_GUARD;
            end
          end
        end
        ST_GUARD: begin
          dropped_d = pulse_i;
          guard_dec = tick_i;
          if (tick_i && guard_is_one) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ONESHOT;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dropped_q <= dropped_d;
    end
  end

  assign level_o     = (state_q == ST_ACTIVE);
  assign busy_o      = (state_q != ST_IDLE);
  assign remaining_o = ((state_q == ST_ACTIVE) && (mode_q != MODE_TOGGLE)) ? hold_cnt : '0;
  assign dropped_o   = dropped_q;
  assign state_o     = state_q;
  assign guard_cnt_o = guard_cnt;

endmodule

// File: tb/tb_pulse_to_level.sv
// Drives a no-guard and a two-tick-guard instance with identical stimulus and
// compares both against a behavioural model of the hold/guard timing.
module tb_pulse_to_level;
  import pulse_to_level_pkg::*;

  localparam int HW = 8;

  // Clock/reset and shared inputs
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse = 1'b0;
  logic          tick = 1'b1;
  logic          clear = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [HW-1:0] hc = '0;

  always #5 clk = ~clk;

  logic          level0, busy0, drop0, level1, busy1, drop1;
  logic [HW-1:0] rem0, rem1;
  state_e        st0, st1;
  logic [0:0]    gc0;
  logic [1:0]    gc1;

  pulse_to_level #(.HOLD_W(HW), .GUARD_TICKS(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .pulse_i(pulse), .tick_i(tick), .mode_i(mode),
    .hold_cycles_i(hc), .clear_i(clear), .level_o(level0), .busy_o(busy0),
    .remaining_o(rem0), .dropped_o(drop0), .state_o(st0), .guard_cnt_o(gc0)
  );

  pulse_to_level #(.HOLD_W(HW), .GUARD_TICKS(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .pulse_i(pulse), .tick_i(tick), .mode_i(mode),
    .hold_cycles_i(hc), .clear_i(clear), .level_o(level1), .busy_o(busy1),
    .remaining_o(rem1), .dropped_o(drop1), .state_o(st1), .guard_cnt_o(gc1)
  );

  // Reference model: level flag, ticks of hold left, ticks of lockout left.
  int gt[2] = '{0, 2};
  bit m_lvl[2];
  int m_left[2];
  int m_lock[2];
  int m_mode[2];
  bit m_drop[2];

  int vectors = 0;
  int miscompares = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_left[i] = 0; m_lock[i] = 0; m_mode[i] = 0; m_drop[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int em;
    em = (mode == 2'd3) ? 0 : int'(mode);
    for (int i = 0; i < 2; i++) begin
      m_drop[i] = 0;
      if (clear) begin
        m_lvl[i] = 0; m_left[i] = 0; m_lock[i] = 0;
      end else if (m_lock[i] > 0) begin
        if (pulse) m_drop[i] = 1;
        if (tick) m_lock[i]--;
      end else if (!m_lvl[i]) begin
        if (pulse) begin
          if (em == 2) begin
            m_lvl[i] = 1; m_mode[i] = 2; m_left[i] = 0;
          end else if (hc == 0) begin
            m_drop[i] = 1;
          end else begin
            m_lvl[i] = 1; m_mode[i] = em; m_left[i] = int'(hc);
          end
        end
      end else if (m_mode[i] == 2) begin
        if (pulse) begin
          m_lvl[i] = 0; m_lock[i] = gt[i];
        end
      end else if (pulse && m_mode[i] == 1 && hc != 0) begin
        m_left[i] = int'(hc);
      end else begin
        if (pulse) m_drop[i] = 1;
        if (tick) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_lvl[i] = 0; m_lock[i] = gt[i];
          end
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic lv, input logic bz, input logic [31:0] rm,
                            input logic dr, input logic [31:0] st, input logic [31:0] gc);
    state_e es;
    es = m_lvl[i] ? ST_ACTIVE : ((m_lock[i] > 0) ? ST_GUARD : ST_IDLE);
    chk($sformatf("g%0d_level", gt[i]), {31'd0, lv}, {31'd0, m_lvl[i]});
    chk($sformatf("g%0d_busy", gt[i]), {31'd0, bz}, {31'd0, m_lvl[i] || (m_lock[i] > 0)});
    chk($sformatf("g%0d_remaining", gt[i]), rm, (m_lvl[i] && m_mode[i] != 2) ? m_left[i] : 0);
    chk($sformatf("g%0d_dropped", gt[i]), {31'd0, dr}, {31'd0, m_drop[i]});
    chk($sformatf("g%0d_state", gt[i]), st, 32'(es));
    chk($sformatf("g%0d_guard_cnt", gt[i]), gc, m_lock[i]);
  endtask

  task automatic check_all();
    check_inst(0, level0, busy0, 32'(rem0), drop0, 32'(st0), 32'(gc0));
    check_inst(1, level1, busy1, 32'(rem1), drop1, 32'(st1), 32'(gc1));
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic cycle(input bit p, input bit t, input logic [1:0] md, input int h, input bit c);
    pulse = p; tick = t; mode = md; hc = HW'(h); clear = c;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a 10-cycle one-shot hold
    cycle(1, 1, 2'd0, 10, 0);
    repeat (4) cycle(0, 1, 2'd0, 10, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_level", {31'd0, level0}, 32'd0);
    chk("async_busy", {31'd0, busy1}, 32'd0);
    chk("async_remaining", 32'(rem1), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 2'd0, 10, 0);
    repeat (11) cycle(0, 1, 2'd0, 10, 0);

    // One-shot, hold 5, second pulse mid-hold is dropped
    for (int i = 0; i < 9; i++) cycle(i == 0 || i == 3, 1, 2'd0, 5, 0);

    // Retrigger, hold 4, reloads at edges 3 and on the expiring edge 7
    for (int i = 0; i < 14; i++) cycle(i == 0 || i == 3 || i == 7, 1, 2'd1, 4, 0);

    // Slow time base: tick every 4th cycle, one-shot hold of 3 ticks
    for (int i = 0; i < 18; i++) cycle(i == 0, (i % 4) == 2, 2'd0, 3, 0);

    // Toggle on, mode change ignored while active, toggle off, pulse in guard
    cycle(1, 1, 2'd2, 7, 0);
    cycle(0, 1, 2'd0, 7, 0);
    cycle(1, 1, 2'd0, 7, 0);
    cycle(0, 0, 2'd2, 7, 0);
    cycle(1, 0, 2'd2, 7, 0);
    cycle(0, 1, 2'd2, 7, 0);
    cycle(0, 0, 2'd2, 7, 0);
    cycle(1, 1, 2'd2, 7, 0);
    cycle(0, 1, 2'd2, 7, 0);

    // Clear with a coincident pulse, then a zero-length hold request
    cycle(1, 1, 2'd0, 5, 0);
    cycle(0, 1, 2'd0, 5, 0);
    cycle(1, 1, 2'd0, 5, 1);
    cycle(0, 1, 2'd0, 5, 0);
    cycle(1, 1, 2'd0, 0, 0);
    cycle(0, 1, 2'd0, 0, 0);
    cycle(1, 1, 2'd3, 2, 0);
    repeat (4) cycle(0, 1, 2'd1, 0, 0);

    // Randomised traffic over all modes, hold lengths, tick rates and clears
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
            2'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
            $urandom_range(0, 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
